rate_counter: RTL and testbench
===============================

# rate_counter

Parametrised multi-rate display counter: an internal rate divider produces a one-cycle step enable at a selectable rate, and a COUNT_WIDTH-bit counter advances on each step. It is the next-generation drop-in for the lab's divider-plus-counter pair. It adds parametrised width and speed count, a pause input, a synchronous load, optional down-counting, and boundary-safe speed changes. It sits between the board clock and the HEX/LED display logic.

## Interface
- CLOCK_FREQUENCY, 4: ClockIn cycles per base period (Speed 1); must be ≥ 1.
- COUNT_WIDTH, 4: CounterValue width; must be ≥ 1.
- NUM_SPEEDS, 4: number of Speed codes; must be ≥ 2; SPEED_W = $clog2(NUM_SPEEDS).
- ClockIn  input  1  sole clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Speed  input  SPEED_W  rate select; sampled only at a period boundary.
- Pause  input  1  high: freeze divider and counter.
- Direction  input  1  0 = up, 1 = down (effective only with RATE_COUNTER_DOWN_EN).
- Load  input  1  synchronous load of LoadValue.
- LoadValue  input  COUNT_WIDTH  value loaded when Load = 1.
- CounterValue  output  COUNT_WIDTH  registered count.
- Tick  output  1  registered; high for exactly one cycle in the cycle after each step.
- Wrap  output  1  registered; high together with Tick when that step wrapped.

## Operation
- Period P(s): P(0) = 1 (step every cycle). For s ≥ 1, P(s) = CLOCK_FREQUENCY · 2^(s−1).
- Speed codes ≥ NUM_SPEEDS (when NUM_SPEEDS is not a power of 2) are treated as NUM_SPEEDS−1.
- Divider is a down-counter `div`, sized to hold P(NUM_SPEEDS−1)−1; all arithmetic is unsigned.
- Priority per edge, highest first: Reset > Load > Pause > normal.
- Reset:
  - div ← P(Speed)−1.
  - CounterValue ← 0, Tick ← 0, Wrap ← 0.
- Load:
  - CounterValue ← LoadValue; div ← P(Speed)−1.
  - Tick ← 0, Wrap ← 0. Load while paused still loads.
- Pause (no Reset/Load):
  - div and CounterValue hold; Tick ← 0, Wrap ← 0.
  - A pending step is deferred, not lost.
- Normal, div ≠ 0:
  - div ← div−1; Tick ← 0, Wrap ← 0.
- Normal, div == 0 (step):
  - div ← P(Speed)−1, using the Speed present this cycle. This is the only point Speed is sampled, so a mid-period Speed change takes effect at the next boundary.
  - Up: CounterValue ← CounterValue+1 mod 2^COUNT_WIDTH; Wrap ← 1 iff old value was all ones.
  - Down: CounterValue ← CounterValue−1 mod 2^COUNT_WIDTH; Wrap ← 1 iff old value was 0.
  - Tick ← 1.
- Direction is sampled at the step edge; changing it never disturbs div.

## Timing
- Reset values: CounterValue = 0, Tick = 0, Wrap = 0.
- First step: on the P(Speed)-th rising edge after the Reset edge, counting non-paused cycles. Subsequent steps are every P cycles.
- CounterValue changes on the step edge. Tick/Wrap are high for the cycle that follows that edge, aligned with the new CounterValue.
- Speed 0: step every non-paused cycle, so Tick stays continuously high.
- Pause asserted for N cycles delays every later step by exactly N cycles.
- Load: new value visible the cycle after the edge; next step P(Speed) non-paused cycles later.
- Reset asserted mid-period: aborts the period; behaviour is identical to power-on reset.
- No combinational path from any input to any output.

## Configuration
- RATE_COUNTER_DOWN_EN defined: Direction selects up or down counting as described above.
- Not defined: Direction port remains but is ignored. The block counts up only, and Wrap flags only the all-ones→0 rollover.

## Test plan
- Reset, Speed=1, CLOCK_FREQUENCY=4 → CounterValue steps 0→1 on the 4th edge, then every 4 edges. Tick high for one cycle per step.
- Speed=0, 20 cycles from reset → CounterValue increments every cycle. It reaches 15, then 0 with Wrap=1, ending at 4; Tick stays high.
- Speed=3 (P=16); switch to Speed=1 at div=10 → current period still lasts 16 cycles; the following periods are 4 cycles.
- Pause held 7 cycles mid-period at Speed=2 → step delayed exactly 7 cycles; CounterValue and Tick frozen/low throughout.
- Load=1 with LoadValue=9 while Pause=1 → CounterValue=9 next cycle. After release, the step to 10 occurs P(Speed) cycles later.
- With RATE_COUNTER_DOWN_EN, Direction=1, Speed=0 from 1 → 1,0,15 with Wrap=1 on the 0→15 step. Without the macro, same stimulus counts 1,2,3.

Source files
------------

// File: rtl/rate_counter.sv
// Multi-rate display counter: a reloadable divider issues a one-cycle step and a
// COUNT_WIDTH-bit counter advances on it. Define RATE_COUNTER_DOWN_EN to enable down-counting.
module rate_counter #(
    parameter int CLOCK_FREQUENCY = 4,
    parameter int COUNT_WIDTH     = 4,
    parameter int NUM_SPEEDS      = 4,
    localparam int SPEED_W        = $clog2(NUM_SPEEDS)
) (
    input  logic                   ClockIn,
    input  logic                   Reset,
    input  logic [SPEED_W-1:0]     Speed,
    input  logic                   Pause,
    input  logic                   Direction,
    input  logic                   Load,
    input  logic [COUNT_WIDTH-1:0] LoadValue,
    output logic [COUNT_WIDTH-1:0] CounterValue,
    output logic                   Tick,
    output logic                   Wrap
);

    localparam int unsigned CLK_FREQ_U = CLOCK_FREQUENCY;
    localparam int unsigned MAX_SPEED  = NUM_SPEEDS - 1;
    localparam int unsigned PERIOD_MAX = CLK_FREQ_U * (32'd1 << (MAX_SPEED - 1));
    localparam int          DIV_W      = (PERIOD_MAX > 1) ? $clog2(PERIOD_MAX) : 1;

    logic [DIV_W-1:0]       div_q, div_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   tick_q, tick_d;
    logic                   wrap_q, wrap_d;
    logic                   count_down;
    logic [DIV_W-1:0]       reload_val;

    // Speed codes beyond the last valid one saturate to the slowest rate.
    function automatic logic [DIV_W-1:0] period_minus_one(input logic [SPEED_W-1:0] s);
        int unsigned sel;
        int unsigned period;
        sel = 32'(s);
        if (sel > MAX_SPEED) begin
            sel = MAX_SPEED;
        end
        if (sel == 0) begin
            period = 1;
        end else begin
            period = CLK_FREQ_U * (32'd1 << (sel - 1));
        end
        return DIV_W'(period - 1);
    endfunction

`ifdef RATE_COUNTER_DOWN_EN
    always_comb count_down = Direction;
`else
    logic unused_direction;
    always_comb unused_direction = Direction;
    always_comb count_down = 1'b0;
`endif

    always_comb reload_val = period_minus_one(Speed);

    always_comb begin
        div_d   = div_q;
        count_d = count_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (Load) begin
            count_d = LoadValue;
            div_d   = reload_val;
        end else if (Pause) begin
            div_d   = div_q;
        end else if (div_q != '0) begin
            div_d   = div_q - 1'b1;
        end else begin
            div_d  = reload_val;
            tick_d = 1'b1;
            if (count_down) begin
                count_d = count_q - 1'b1;
                wrap_d  = (count_q == '0);
            end else begin
                count_d = count_q + 1'b1;
                wrap_d  = &count_q;
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            div_q   <= reload_val;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        CounterValue = count_q;
        Tick         = tick_q;
        Wrap         = wrap_q;
    end

endmodule

// File: tb/tb_rate_counter.sv
// Directed bench for rate_counter at default parameters (CLOCK_FREQUENCY=4, COUNT_WIDTH=4, NUM_SPEEDS=4).
module tb_rate_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt;
    logic       tick;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    rate_counter #(
        .CLOCK_FREQUENCY(4),
        .COUNT_WIDTH(4),
        .NUM_SPEEDS(4)
    ) dut (
        .ClockIn(clk),
        .Reset(rst),
        .Speed(speed),
        .Pause(pause),
        .Direction(dir),
        .Load(load),
        .LoadValue(load_val),
        .CounterValue(cnt),
        .Tick(tick),
        .Wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] s);
        speed = s;
        pause = 1'b0;
        load  = 1'b0;
        dir   = 1'b0;
        rst   = 1'b1;
        edge_wait();
        rst   = 1'b0;
    endtask

    initial begin
        // Speed 1: step every 4 edges
        do_reset(2'd1);
        check("reset cnt", 32'(cnt), 0);
        check("reset tick", 32'(tick), 0);
        check("reset wrap", 32'(wrap), 0);
        for (int k = 1; k <= 12; k++) begin
            edge_wait();
            check($sformatf("s1 cnt e%0d", k), 32'(cnt), 32'(k / 4));
            check($sformatf("s1 tick e%0d", k), 32'(tick), (k % 4 == 0) ? 1 : 0);
        end

        // Speed 0: step every edge, wraps 15 -> 0
        do_reset(2'd0);
        for (int k = 1; k <= 20; k++) begin
            edge_wait();
            check($sformatf("s0 cnt e%0d", k), 32'(cnt), 32'(k % 16));
            check($sformatf("s0 tick e%0d", k), 32'(tick), 1);
            check($sformatf("s0 wrap e%0d", k), 32'(wrap), (k == 16) ? 1 : 0);
        end

        // Speed 3 then switch to Speed 1 mid-period (div=10 after edge 5)
        do_reset(2'd3);
        for (int k = 1; k <= 24; k++) begin
            edge_wait();
            if (k == 5) speed = 2'd1;
            check($sformatf("sw cnt e%0d", k), 32'(cnt), (k < 16) ? 0 : 32'(1 + (k - 16) / 4));
            check($sformatf("sw tick e%0d", k), 32'(tick), (k >= 16 && (k - 16) % 4 == 0) ? 1 : 0);
        end

        // Speed 2 (P=8), pause 7 cycles after edge 3: step moves from edge 8 to 15
        do_reset(2'd2);
        for (int k = 1; k <= 23; k++) begin
            pause = (k >= 4 && k <= 10);
            edge_wait();
            check($sformatf("pz cnt e%0d", k), 32'(cnt), (k < 15) ? 0 : (k < 23) ? 1 : 2);
            check($sformatf("pz tick e%0d", k), 32'(tick), (k == 15 || k == 23) ? 1 : 0);
        end
        pause = 1'b0;

        // Load while paused, then step P(1)=4 non-paused edges later
        do_reset(2'd1);
        edge_wait();
        edge_wait();
        pause    = 1'b1;
        load     = 1'b1;
        load_val = 4'd9;
        edge_wait();
        load = 1'b0;
        check("ld cnt", 32'(cnt), 9);
        check("ld tick", 32'(tick), 0);
        edge_wait();
        edge_wait();
        check("ld hold cnt", 32'(cnt), 9);
        pause = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            edge_wait();
            check($sformatf("ld cnt e%0d", k), 32'(cnt), (k < 4) ? 9 : 10);
            check($sformatf("ld tick e%0d", k), 32'(tick), (k == 4) ? 1 : 0);
        end

        // Load 15 at Speed 0: next edge wraps to 0
        speed    = 2'd0;
        load     = 1'b1;
        load_val = 4'd15;
        edge_wait();
        load = 1'b0;
        check("ld15 cnt", 32'(cnt), 15);
        edge_wait();
        check("ld15 wrap cnt", 32'(cnt), 0);
        check("ld15 wrap", 32'(wrap), 1);
        check("ld15 tick", 32'(tick), 1);

        // Reset mid-period aborts it
        do_reset(2'd1);
        edge_wait();
        edge_wait();
        do_reset(2'd1);
        check("rst2 cnt", 32'(cnt), 0);
        check("rst2 tick", 32'(tick), 0);
        for (int k = 1; k <= 4; k++) begin
            edge_wait();
            check($sformatf("rst2 cnt e%0d", k), 32'(cnt), (k < 4) ? 0 : 1);
        end

        // Direction=1 at Speed 0 starting from 1
        speed    = 2'd0;
        load     = 1'b1;
        load_val = 4'd1;
        edge_wait();
        load = 1'b0;
        dir  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            edge_wait();
`ifdef RATE_COUNTER_DOWN_EN
            check($sformatf("dn cnt e%0d", k), 32'(cnt), (k == 1) ? 0 : (k == 2) ? 15 : 14);
            check($sformatf("dn wrap e%0d", k), 32'(wrap), (k == 2) ? 1 : 0);
`else
            check($sformatf("dn cnt e%0d", k), 32'(cnt), 32'(1 + k));
            check($sformatf("dn wrap e%0d", k), 32'(wrap), 0);
`endif
        end
        dir = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
